piso_shiftreg: RTL and testbench

Parallel-in, serial-out shift register: the transmit-side counterpart of the 8-bit serial-in/parallel-out `shiftreg`. It accepts a WIDTH-bit word over a valid/ready handshake and emits it one bit per enabled clock on a single serial line, with framing strobes. A one-word holding register allows the next word to be accepted while the current one is shifting, so words can stream back-to-back with no idle bit between them.

---
 rtl/piso_shiftreg.sv | 104 ++++++++++
 tb/tb_piso_shiftreg.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/piso_shiftreg.sv
// piso_shiftreg: accepts a WIDTH-bit word over valid/ready and emits it one bit per enabled clock, with framing strobes.
// Latency: first bit on o_serial one cycle after acceptance; consecutive words stream with no idle bit between them.
// Backpressure: o_ready is low while the one-word holding register is occupied (and during reset); i_valid is ignored then.
//
// Ports:
//   i_clk, i_rst                 clock, synchronous active-high reset
//   i_data, i_valid, o_ready     parallel word input handshake
//   i_shift_en                   bit strobe; the current bit is consumed on an edge where it is 1
//   o_serial, o_bit_valid        serial data bit and its qualifier (o_serial is 0 when idle)
//   o_first, o_last              current bit is the first / final bit of its word
//   o_busy                       shifter active or a word waiting in the holding register
module piso_shiftreg #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic             i_shift_en,
  output logic             o_serial,
  output logic             o_bit_valid,
  output logic             o_first,
  output logic             o_last,
  output logic             o_busy
);

  localparam int            CW       = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] hold_data;
  logic             hold_valid;
  logic [WIDTH-1:0] sreg;
  logic [CW-1:0]    cnt;

  logic             accept;
  logic             load;
  logic             step;
  logic             last_bit;
  logic [WIDTH-1:0] sreg_shifted;

  // The holding register is the only thing that can refuse a word.
  assign o_ready  = !hold_valid && !i_rst;
  assign accept   = i_valid && o_ready;

  assign step     = (state == SHIFT) && i_shift_en;
  assign last_bit = (cnt == LAST_IDX);

  // A held word enters the shifter either straight away when idle, or on the
  // same edge that consumes the final bit of the current word, so no idle bit
  // appears between consecutive words.
  assign load     = hold_valid && ((state == IDLE) || (step && last_bit));

  // Move the next bit toward the output end, zero-filling behind it.
  assign sreg_shifted = MSB_FIRST ? {sreg[WIDTH-2:0], 1'b0}
                                  : {1'b0, sreg[WIDTH-1:1]};

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state      <= IDLE;
      hold_data  <= '0;
      hold_valid <= 1'b0;
      sreg       <= '0;
      cnt        <= '0;
    end else begin
      // accept and load never coincide: accept needs an empty holding
      // register, load needs a full one.
      if (accept) begin
        hold_data  <= i_data;
        hold_valid <= 1'b1;
      end

      if (load) begin
        sreg       <= hold_data;
        cnt        <= '0;
        state      <= SHIFT;
        hold_valid <= 1'b0;
      end else if (step) begin
        if (last_bit) begin
          state <= IDLE;
          sreg  <= '0;
          cnt   <= '0;
        end else begin
          sreg <= sreg_shifted;
          cnt  <= cnt + 1'b1;
        end
      end
    end
  end

  assign o_bit_valid = (state == SHIFT);
  assign o_serial    = o_bit_valid ? (MSB_FIRST ? sreg[WIDTH-1] : sreg[0]) : 1'b0;
  assign o_first     = o_bit_valid && (cnt == '0);
  assign o_last      = o_bit_valid && last_bit;
  assign o_busy      = (state == SHIFT) || hold_valid;

endmodule

// File: tb/tb_piso_shiftreg.sv
// tb_piso_shiftreg: drives an MSB-first and an LSB-first instance with identical stimulus and
// scores every cycle against a word-queue reference model; also reconstructs each word from
// the serial line on the consuming edges and compares it with the word that was sent.
module tb_piso_shiftreg;

  localparam int W = 8;

  logic         i_clk;
  logic         i_rst;
  logic [W-1:0] i_data;
  logic         i_valid;
  logic         i_shift_en;

  logic a_ready, a_serial, a_bit_valid, a_first, a_last, a_busy;
  logic b_ready, b_serial, b_bit_valid, b_first, b_last, b_busy;

  piso_shiftreg #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_msb (
    .i_clk(i_clk), .i_rst(i_rst), .i_data(i_data), .i_valid(i_valid), .o_ready(a_ready),
    .i_shift_en(i_shift_en), .o_serial(a_serial), .o_bit_valid(a_bit_valid),
    .o_first(a_first), .o_last(a_last), .o_busy(a_busy)
  );

  piso_shiftreg #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_lsb (
    .i_clk(i_clk), .i_rst(i_rst), .i_data(i_data), .i_valid(i_valid), .o_ready(b_ready),
    .i_shift_en(i_shift_en), .o_serial(b_serial), .o_bit_valid(b_bit_valid),
    .o_first(b_first), .o_last(b_last), .o_busy(b_busy)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // ---------------- reference model ----------------
  // q holds every accepted word not yet fully emitted; q[0] is on the line when m_active.
  logic [W-1:0] q[$];
  bit           m_active;
  int           m_idx;
  logic [W-1:0] rx_a, rx_b;
  logic [W-1:0] lb_a, lb_b, lb_exp;
  int           lb_cnt;

  int checks;
  int errors;
  int tmo_cnt;
  bit mon_en;
  bit done;
  int en_mode;  // 0: always 1, 1: toggle, 2: random

  function automatic bit m_ready();
    // Holding register is free when the only queued word (if any) is the one shifting.
    return !i_rst && (q.size() == (m_active ? 1 : 0));
  endfunction

  initial begin
    m_active = 1'b0;
    m_idx    = 0;
    lb_cnt   = 0;
    rx_a     = '0;
    rx_b     = '0;
  end

  always @(posedge i_clk) begin
    bit hs;
    hs = i_valid && m_ready();
    if (i_rst) begin
      q.delete();
      m_active = 1'b0;
      m_idx    = 0;
    end else begin
      if (m_active && i_shift_en) begin
        rx_a = {rx_a[W-2:0], a_serial};
        rx_b = {b_serial, rx_b[W-1:1]};
        if (m_idx == W - 1) begin
          lb_a   = rx_a;
          lb_b   = rx_b;
          lb_exp = q[0];
          lb_cnt++;
          void'(q.pop_front());
          m_idx    = 0;
          m_active = (q.size() > 0);
        end else begin
          m_idx++;
        end
      end else if (!m_active && q.size() > 0) begin
        m_active = 1'b1;
        m_idx    = 0;
      end
      if (hs) q.push_back(i_data);
    end
  end

  // ---------------- monitor ----------------
  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  int lb_seen;
  initial begin
    checks  = 0;
    errors  = 0;
    lb_seen = 0;
  end

  always @(negedge i_clk) begin
    if (mon_en) begin
      logic [W-1:0] w;
      int  bv, ea, eb;
      w  = (q.size() > 0) ? q[0] : '0;
      bv = m_active ? 1 : 0;
      ea = m_active ? int'(w[W-1-m_idx]) : 0;
      eb = m_active ? int'(w[m_idx]) : 0;
      chk("ready_msb", int'(a_ready), int'(m_ready()));
      chk("ready_lsb", int'(b_ready), int'(m_ready()));
      chk("busy_msb", int'(a_busy), (q.size() > 0) ? 1 : 0);
      chk("busy_lsb", int'(b_busy), (q.size() > 0) ? 1 : 0);
      chk("bit_valid_msb", int'(a_bit_valid), bv);
      chk("bit_valid_lsb", int'(b_bit_valid), bv);
      chk("serial_msb", int'(a_serial), ea);
      chk("serial_lsb", int'(b_serial), eb);
      chk("first_msb", int'(a_first), (m_active && m_idx == 0) ? 1 : 0);
      chk("first_lsb", int'(b_first), (m_active && m_idx == 0) ? 1 : 0);
      chk("last_msb", int'(a_last), (m_active && m_idx == W - 1) ? 1 : 0);
      chk("last_lsb", int'(b_last), (m_active && m_idx == W - 1) ? 1 : 0);
      if (lb_cnt != lb_seen) begin
        chk("loopback_msb", int'(lb_a), int'(lb_exp));
        chk("loopback_lsb", int'(lb_b), int'(lb_exp));
        lb_seen = lb_cnt;
      end
    end
    if (done) begin
      chk("timeouts", tmo_cnt, 0);
      chk("drained", q.size(), 0);
      done = 1'b0;
    end
  end

  // ---------------- shift-enable driver ----------------
  initial i_shift_en = 1'b1;
  always @(posedge i_clk) begin
    #1;
    case (en_mode)
      0:       i_shift_en = 1'b1;
      1:       i_shift_en = !i_shift_en;
      default: i_shift_en = 1'($urandom_range(0, 1));
    endcase
  end

  // ---------------- stimulus ----------------
  task automatic send(input logic [W-1:0] d);
    int n;
    n = 0;
    i_valid = 1'b1;
    i_data  = d;
    @(negedge i_clk);
    while (!m_ready() && n < 200) begin
      n++;
      @(negedge i_clk);
    end
    if (n >= 200) tmo_cnt++;
    @(posedge i_clk);
    #1;
    i_valid = 1'b0;
    i_data  = W'($urandom);
  endtask

  task automatic drain(input int limit);
    int n;
    n = 0;
    @(negedge i_clk);
    while ((q.size() > 0 || m_active) && n < limit) begin
      n++;
      @(negedge i_clk);
    end
    if (n >= limit) tmo_cnt++;
    repeat (2) @(negedge i_clk);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge i_clk);
    #1;
  endtask

  initial begin
    int n;
    tmo_cnt = 0;
    mon_en  = 1'b0;
    done    = 1'b0;
    en_mode = 0;
    i_rst   = 1'b1;
    i_valid = 1'b0;
    i_data  = '0;
    repeat (2) @(posedge i_clk);
    #1;
    mon_en = 1'b1;          // o_ready must read 0 while reset is still asserted
    idle(1);
    i_rst = 1'b0;
    idle(1);

    // single word, continuous enable
    send(8'hA5);
    drain(100);

    // back-to-back words
    send(8'hA5);
    send(8'h3C);
    drain(100);

    // enable toggling: each bit held two cycles
    en_mode = 1;
    send(8'hA5);
    drain(100);
    en_mode = 0;

    // backpressure: third word waits until the held word loads
    send(8'hA5);
    send(8'h3C);
    send(8'hFF);
    drain(100);

    // reset mid-word with a word held
    send(8'hA5);
    send(8'h3C);
    n = 0;
    @(negedge i_clk);
    while (!(m_active && m_idx == 3) && n < 100) begin
      n++;
      @(negedge i_clk);
    end
    if (n >= 100) tmo_cnt++;
    @(posedge i_clk);
    #1;
    i_rst = 1'b1;
    idle(1);
    i_rst = 1'b0;
    idle(4);

    // single set bit: LSB-first instance leads with it, MSB-first trails with it
    send(8'h01);
    drain(100);
    send(8'h80);
    drain(100);

    // randomized stream with random enable and random gaps
    en_mode = 2;
    for (int k = 0; k < 40; k++) begin
      send(W'($urandom));
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 4));
    end
    drain(3000);

    // random mid-stream reset
    send(W'($urandom));
    send(W'($urandom));
    idle($urandom_range(1, 6));
    i_rst = 1'b1;
    idle(1);
    i_rst = 1'b0;
    en_mode = 0;
    send(8'h5A);
    drain(100);

    done = 1'b1;
    repeat (3) @(negedge i_clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
